// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 divider: restoring radix-2 mantissa divide, round-to-nearest-even,
// valid/ready handshakes on both sides and four exception flags.
module fp_div_seq #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;
    localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t                 r_state, w_next_state;
    logic [MAN_W+1:0]       r_rem;
    logic [MAN_W:0]         r_div;
    logic [MAN_W+2:0]       r_quot;
    logic signed [EW2-1:0]  r_exp;
    logic                   r_sign;
    logic [CNT_W-1:0]       r_cnt;
    logic [W-1:0]           r_result;
    logic [3:0]             r_flags;

    // Operand decode straight off the input bus; denormals (exp==0) count as zero.
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;

    assign w_ea     = operand_a[W-2 -: EXP_W];
    assign w_eb     = operand_b[W-2 -: EXP_W];
    assign w_fa     = operand_a[MAN_W-1:0];
    assign w_fb     = operand_b[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (w_fa != '0);
    assign w_b_nan  = (&w_eb) && (w_fb != '0);
    assign w_sign   = operand_a[W-1] ^ operand_b[W-1];

    // Special-case classification in priority order; w_special selects the one-cycle path.
    logic         w_special;
    logic [W-1:0] w_spec_result;
    logic [3:0]   w_spec_flags;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch.
    always_comb begin
        w_special     = 1'b1;
        w_spec_result = '0;
        w_spec_flags  = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_result = QNAN;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_result = QNAN;
            w_spec_flags  = 4'b1000;
        end else if (w_b_zero && !w_a_inf) begin
            w_spec_result = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_flags  = 4'b0100;
        end else if (w_a_inf) begin
            w_spec_result = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero || w_b_inf) begin
            w_spec_result = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // One shared restoring step: fed from the input bus on the capture edge (first
    // quotient bit) and from the remainder register for the remaining MAN_W+2 bits.
    logic [MAN_W+1:0] w_rem_src, w_rem_keep, w_rem_next;
    logic [MAN_W:0]   w_div_src;
    logic [MAN_W+2:0] w_diff;
    logic             w_qbit;

    assign w_rem_src  = (r_state == S_IDLE) ? {2'b01, w_fa} : r_rem;
    assign w_div_src  = (r_state == S_IDLE) ? {1'b1, w_fb}  : r_div;
    assign w_diff     = {1'b0, w_rem_src} - {2'b00, w_div_src};
    assign w_qbit     = ~w_diff[MAN_W+2];
    assign w_rem_keep = w_qbit ? w_diff[MAN_W+1:0] : w_rem_src;
    // The kept remainder is always below the divisor, so its top bit is zero before the shift.
    assign w_rem_next = {w_rem_keep[MAN_W:0], 1'b0};

    logic [EW2-1:0] w_exp_init;
    assign w_exp_init = {2'b00, w_ea} - {2'b00, w_eb} + EW2'(BIAS);

    // Normalise, round to nearest even and range-check the finished quotient.
    logic                  w_top, w_guard, w_sticky, w_inc, w_carry, w_ovf, w_unf;
    logic [MAN_W-1:0]      w_frac, w_frac_r;
    logic signed [EW2-1:0] w_exp_n, w_exp_r;
    logic [W-1:0]          w_norm_result;

    assign w_top    = r_quot[MAN_W+2];
    assign w_frac   = w_top ? r_quot[MAN_W+1:2] : r_quot[MAN_W:1];
    assign w_guard  = w_top ? r_quot[1] : r_quot[0];
    assign w_sticky = (w_top & r_quot[0]) | (|r_rem);
    assign w_exp_n  = w_top ? r_exp : r_exp - EXP_ONE;
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);
    // A fraction carry means the mantissa rounded up to 2.0: fraction wraps to 0, exponent +1.
    assign {w_carry, w_frac_r} = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
    assign w_exp_r  = w_carry ? w_exp_n + EXP_ONE : w_exp_n;
    assign w_ovf    = (w_exp_r >= EXP_MAX);
    assign w_unf    = (w_exp_r <= EXP_ZERO);
    assign w_norm_result = w_ovf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                           w_unf ? {r_sign, {(W-1){1'b0}}} :
                                   {r_sign, w_exp_r[EXP_W-1:0], w_frac_r};

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next_state = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (r_cnt == CNT_W'(MAN_W + 1)) w_next_state = S_NORM;
            S_NORM:   w_next_state = S_DONE;
            S_DONE:   if (out_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: capture/first step, iterate, then register the rounded result or special.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_div    <= '0;
            r_quot   <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    if (w_special) begin
                        r_result <= w_spec_result;
                        r_flags  <= w_spec_flags;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_div  <= {1'b1, w_fb};
                        r_quot <= {{(MAN_W+2){1'b0}}, w_qbit};
                        r_exp  <= w_exp_init;
                        r_sign <= w_sign;
                        r_cnt  <= '0;
                    end
                end
                S_DIVIDE: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[MAN_W+1:0], w_qbit};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    r_result <= w_norm_result;
                    r_flags  <= {2'b00, w_ovf, w_unf & ~w_ovf};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq at default single-precision widths.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one operation and check its result. lat is the number of rising edges after the
    // transfer edge until the first edge that sees out_valid high. With hold>0, out_ready stays
    // low for hold cycles while outputs must stay frozen and a stray in_valid must be ignored.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags,
                         input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid  = 1'b0;
            operand_a = 32'hDEAD_BEEF;
            operand_b = 32'h1234_5678;
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, ".lat"},    64'(lat),       64'(exp_lat));
        check({tag, ".result"}, 64'(result),    64'(exp_res));
        check({tag, ".flags"},  64'(flags),     64'(exp_flags));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid  = 1'b1;
                operand_a = 32'h4000_0000;
                operand_b = 32'h3F80_0000;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, ".hold_valid"},  64'(out_valid), 64'd1);
            check({tag, ".hold_result"}, 64'(result),    64'(exp_res));
            check({tag, ".hold_ready"},  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".post_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        operand_a = 32'h3F80_0000;
        operand_b = 32'h3F80_0000;
        repeat (3) @(negedge clk);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result",    64'(result),    64'd0);
        check("rst.flags",     64'(flags),     64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst.no_transfer", 64'(in_ready), 64'd1);

        // Normal operands: result and flags computed by hand.
        do_op("one_by_one",  32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 27, 0);
        do_op("one_by_three",32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 27, 0);
        do_op("neg_sign",    32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000, 4'b0000, 27, 0);
        do_op("three_by_two",32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 4'b0000, 27, 0);
        do_op("one_by_1p5",  32'h3F80_0000, 32'h3FC0_0000, 32'h3F2A_AAAB, 4'b0000, 27, 0);
        // Special cases, resolved on the capture edge.
        do_op("div_zero",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1, 0);
        do_op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1, 0);
        do_op("inf_by_one",  32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0000, 1, 0);
        do_op("nan_in",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 1, 0);
        do_op("neg_by_inf",  32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000, 1, 0);
        do_op("denorm_flush",32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1, 0);
        // Range limits after rounding.
        do_op("overflow",    32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 4'b0010, 27, 0);
        do_op("underflow",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 27, 0);

        // Output back-pressure; the stray in_valid during DONE must not start an operation.
        do_op("hold",        32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 27, 5);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("hold.no_extra_result", 64'(seen), 64'd0);

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        operand_a = 32'h3F80_0000;
        operand_b = 32'h4040_0000;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.result",    64'(result),    64'd0);
        check("midrst.in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst.no_output", 64'(seen), 64'd0);
        do_op("after_rst",   32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 27, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
